zacore_rf_mp: RTL and testbench
===============================

ZACORE_RF_MP -- requirements
Module: zacore_rf_mp

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, architectural register count (power of two, >=2); IDX_W = $clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, number of read ports (>=1).
REQ-004 Parameter NUM_WR, default 2, number of write ports (>=1).
REQ-005 Parameter ZERO_REG, default 1: 1 hardwires register 0 to zero; 0 makes register 0 ordinary.
REQ-006 i_clk  input  1  single clock, all state updates on posedge.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 rs_index  input  NUM_RD x IDX_W  read port register indices.
REQ-009 rs_data  output  NUM_RD x XLEN  read port data, combinational.
REQ-010 rs_busy  output  NUM_RD  scoreboard pending-write flag per read port, combinational.
REQ-011 rd_index  input  NUM_WR x IDX_W  write port register indices.
REQ-012 rd_data  input  NUM_WR x XLEN  write port data.
REQ-013 rd_write_enable  input  NUM_WR  per-port write strobe.
REQ-014 reserve_valid  input  1  marks reserve_index as awaiting a future write.
REQ-015 reserve_index  input  IDX_W  register to reserve.
REQ-016 o_ready  output  1  high when the file is initialised and accepting traffic.

Function
REQ-017 State machine has two states: CLEAR, RUN; i_rst high forces CLEAR with clear counter = 0 on the next edge.
REQ-018 In CLEAR, one register per cycle is written with zero at index = counter, counter increments; after index NUM_REGS-1 is written, state goes to RUN; CLEAR lasts exactly NUM_REGS cycles after i_rst deasserts.
REQ-019 o_ready is 0 during reset and CLEAR, 1 in RUN (registered state, not combinational on i_rst).
REQ-020 While o_ready = 0: rs_data = 0, rs_busy = 0, all writes and reserves ignored.
REQ-021 i_rst asserted mid-CLEAR restarts the counter at 0; asserted in RUN returns to CLEAR.
REQ-022 In RUN, a write on port w with rd_write_enable[w] = 1 updates register rd_index[w] with rd_data[w] at the next edge.
REQ-023 Multiple enabled write ports to the same index in one cycle: highest-numbered port wins, for storage and for bypass.
REQ-024 Reads are zero-latency: rs_data[r] = enabled same-cycle write data to rs_index[r] (per REQ-023) if any, else stored value.
REQ-025 With ZERO_REG = 1: writes to index 0 discarded, rs_data for index 0 is always 0 with no bypass, reserves to index 0 ignored, index 0 never busy.
REQ-026 Scoreboard: one busy bit per register; reserve_valid sets busy[reserve_index] at the next edge.
REQ-027 Any enabled write to index i clears busy[i] at the next edge.
REQ-028 Reserve and write to the same index in the same cycle: busy ends set (reserve wins; the write still updates data).
REQ-029 rs_busy[r] = busy[rs_index[r]] AND NOT (enabled same-cycle write to rs_index[r]); reserves take effect only from the following cycle.
REQ-030 Re-reserving an already busy register is legal and leaves it busy.

Reset
REQ-031 On i_rst high, all busy bits clear at the next edge; register contents become zero only through the CLEAR sequence.
REQ-032 After reset completes (first RUN cycle), every register reads 0 and every rs_busy is 0.

Verification
REQ-033 Reset, NUM_REGS=32: o_ready low 32 cycles after i_rst falls, high on 33rd; every index then reads 0.
REQ-034 Port0 and port1 both write index 5 (0xAAAA_0000, 0x5555_1111) same cycle with rs_index[0]=5 -> rs_data[0]=0x5555_1111 that cycle and after.
REQ-035 Write 0xDEAD_BEEF to index 0, ZERO_REG=1 -> index 0 reads 0; with ZERO_REG=0 -> reads 0xDEAD_BEEF next cycle.
REQ-036 Reserve index 7, next cycle rs_busy=1; write index 7 -> rs_busy=0 in the write cycle; reserve+write index 7 same cycle -> busy=1 afterwards.
REQ-037 i_rst asserted at CLEAR counter 10 after registers held 0x1234 -> counter restarts, full 32-cycle CLEAR, all registers read 0, no busy bits.
REQ-038 Writes and reserve issued while o_ready=0 -> no register or busy change observable after RUN entry.

Source files
------------

// File: rtl/zacore_rf_mp.sv
// Multi-ported register file with a per-register busy scoreboard, write-to-read
// bypass and a self-clearing start-up sequence that zeroes every register.
module zacore_rf_mp #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int ZERO_REG = 1,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_RD-1:0][IDX_W-1:0]   rs_index,
    output logic [NUM_RD-1:0][XLEN-1:0]    rs_data,
    output logic [NUM_RD-1:0]              rs_busy,
    input  logic [NUM_WR-1:0][IDX_W-1:0]   rd_index,
    input  logic [NUM_WR-1:0][XLEN-1:0]    rd_data,
    input  logic [NUM_WR-1:0]              rd_write_enable,
    input  logic                           reserve_valid,
    input  logic [IDX_W-1:0]               reserve_index,
    output logic                           o_ready
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic [XLEN-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic               w_run;

    function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_CLEAR) begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
            if (r_cnt == LAST_IDX) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_run   = (r_state == S_RUN);
    assign o_ready = w_run;

    // NOTE: the storage array has no reset branch; it is zeroed one entry per
    // cycle by the CLEAR walk, which keeps it mappable onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else begin
            // NOTE: non-blocking assignments in port order: the last one
            // scheduled to an index wins, giving highest-port priority.
            for (int w = 0; w < NUM_WR; w++) begin
                if (rd_write_enable[w] && !is_zero_reg(rd_index[w])) begin
                    r_regs[rd_index[w]] <= rd_data[w];
                end
            end
        end
    end

    // Writes retire a pending reservation; a reserve in the same cycle overrides.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (rd_write_enable[w]) begin
                    r_busy[rd_index[w]] <= 1'b0;
                end
            end
            if (reserve_valid && !is_zero_reg(reserve_index)) begin
                r_busy[reserve_index] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rs_data[r] = r_regs[rs_index[r]];
            rs_busy[r] = r_busy[rs_index[r]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (rd_write_enable[w] && (rd_index[w] == rs_index[r])) begin
                    rs_data[r] = rd_data[w];
                    rs_busy[r] = 1'b0;
                end
            end
            if (is_zero_reg(rs_index[r]) || !w_run) begin
                rs_data[r] = '0;
                rs_busy[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zacore_rf_mp.sv
// Directed bench for zacore_rf_mp: start-up clear, bypass, priority, zero
// register, scoreboard and reset-during-clear behaviour.
module tb_zacore_rf_mp;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic [1:0][4:0]       rs_index;
    logic [1:0][31:0]      rs_data;
    logic [1:0]            rs_busy;
    logic [1:0][31:0]      rs_data_nz;
    logic [1:0]            rs_busy_nz;
    logic [1:0][4:0]       rd_index;
    logic [1:0][31:0]      rd_data;
    logic [1:0]            rd_write_enable;
    logic                  reserve_valid;
    logic [4:0]            reserve_index;
    logic                  o_ready;
    logic                  o_ready_nz;

    int n_pass  = 0;
    int n_total = 0;
    int n_low;

    always #5 i_clk = ~i_clk;

    zacore_rf_mp #(.ZERO_REG(1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .rs_index(rs_index), .rs_data(rs_data), .rs_busy(rs_busy),
        .rd_index(rd_index), .rd_data(rd_data), .rd_write_enable(rd_write_enable),
        .reserve_valid(reserve_valid), .reserve_index(reserve_index),
        .o_ready(o_ready)
    );

    zacore_rf_mp #(.ZERO_REG(0)) u_dut_nz (
        .i_clk(i_clk), .i_rst(i_rst),
        .rs_index(rs_index), .rs_data(rs_data_nz), .rs_busy(rs_busy_nz),
        .rd_index(rd_index), .rd_data(rd_data), .rd_write_enable(rd_write_enable),
        .reserve_valid(reserve_valid), .reserve_index(reserve_index),
        .o_ready(o_ready_nz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_write_enable = '0;
        rd_index        = '0;
        rd_data         = '0;
        reserve_valid   = 1'b0;
        reserve_index   = '0;
    endtask

    // Counts cycles with o_ready low from now, bounded so a stuck DUT cannot hang.
    task automatic wait_ready(output int n);
        n = 0;
        while (!o_ready && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs_index[0] = 5'(i);
            rs_index[1] = 5'(31 - i);
            #1;
            check($sformatf("%s_data_%0d", tag, i), rs_data[0], 32'h0);
            check($sformatf("%s_busy_%0d", tag, i), rs_busy[0], 1'b0);
            check($sformatf("%s_nz_data_%0d", tag, i), rs_data_nz[0], 32'h0);
            check($sformatf("%s_nz_busy_%0d", tag, i), rs_busy_nz[0], 1'b0);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        rs_index = '0;
        idle_inputs();
        tick();
        tick();
        check("rst_ready", o_ready, 1'b0);

        // Release reset and push traffic during CLEAR; it must all be ignored.
        i_rst         = 1'b0;
        rd_index[0]   = 5'd2;
        rd_data[0]    = 32'h1111_2222;
        rd_write_enable = 2'b01;
        reserve_valid = 1'b1;
        reserve_index = 5'd4;
        rs_index[0]   = 5'd2;
        rs_index[1]   = 5'd4;
        #1;
        check("clear_rs_data", rs_data[0], 32'h0);
        check("clear_rs_busy", rs_busy[1], 1'b0);
        for (int k = 0; k < 6; k++) tick();
        idle_inputs();
        wait_ready(n_low);
        check("clear_len", 32'(n_low + 6), 32'd32);
        check("clear_ready_nz", o_ready_nz, 1'b1);
        check_all_zero("init");

        // Two ports hit index 5 in one cycle: port 1 wins, bypass and storage.
        rd_index        = {5'd5, 5'd5};
        rd_data         = {32'h5555_1111, 32'hAAAA_0000};
        rd_write_enable = 2'b11;
        rs_index        = {5'd6, 5'd5};
        #1;
        check("prio_bypass", rs_data[0], 32'h5555_1111);
        tick();
        idle_inputs();
        #1;
        check("prio_stored", rs_data[0], 32'h5555_1111);

        // Distinct indices on the two ports, read back on both read ports.
        rd_index        = {5'd10, 5'd9};
        rd_data         = {32'h1010_1010, 32'h0909_0909};
        rd_write_enable = 2'b11;
        rs_index        = {5'd10, 5'd9};
        #1;
        check("dual_bypass_p0", rs_data[0], 32'h0909_0909);
        check("dual_bypass_p1", rs_data[1], 32'h1010_1010);
        tick();
        idle_inputs();
        #1;
        check("dual_stored_p0", rs_data[0], 32'h0909_0909);
        check("dual_stored_p1", rs_data[1], 32'h1010_1010);

        // Register zero: hardwired in u_dut, ordinary in u_dut_nz.
        rd_index[0]     = 5'd0;
        rd_data[0]      = 32'hDEAD_BEEF;
        rd_write_enable = 2'b01;
        rs_index[0]     = 5'd0;
        #1;
        check("r0_bypass_zr", rs_data[0], 32'h0);
        check("r0_bypass_nz", rs_data_nz[0], 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #1;
        check("r0_stored_zr", rs_data[0], 32'h0);
        check("r0_stored_nz", rs_data_nz[0], 32'hDEAD_BEEF);

        // Scoreboard on index 7.
        rs_index      = {5'd8, 5'd7};
        reserve_valid = 1'b1;
        reserve_index = 5'd7;
        #1;
        check("rsv_same_cycle", rs_busy[0], 1'b0);
        tick();
        idle_inputs();
        #1;
        check("rsv_busy", rs_busy[0], 1'b1);
        check("rsv_other", rs_busy[1], 1'b0);
        rd_index[0]     = 5'd7;
        rd_data[0]      = 32'h0000_0077;
        rd_write_enable = 2'b01;
        #1;
        check("wr_busy_bypass", rs_busy[0], 1'b0);
        check("wr_data_bypass", rs_data[0], 32'h0000_0077);
        tick();
        idle_inputs();
        #1;
        check("wr_busy_after", rs_busy[0], 1'b0);
        rd_index[0]     = 5'd7;
        rd_data[0]      = 32'h0000_0078;
        rd_write_enable = 2'b01;
        reserve_valid   = 1'b1;
        reserve_index   = 5'd7;
        tick();
        idle_inputs();
        #1;
        check("rsv_wr_busy", rs_busy[0], 1'b1);
        check("rsv_wr_data", rs_data[0], 32'h0000_0078);
        reserve_valid = 1'b1;
        reserve_index = 5'd7;
        tick();
        idle_inputs();
        #1;
        check("rersv_busy", rs_busy[0], 1'b1);

        // Reserving index 0 only sticks when it is an ordinary register.
        reserve_valid = 1'b1;
        reserve_index = 5'd0;
        rs_index[0]   = 5'd0;
        tick();
        idle_inputs();
        #1;
        check("rsv0_zr", rs_busy[0], 1'b0);
        check("rsv0_nz", rs_busy_nz[0], 1'b1);

        // Fill every register with 0x1234, then reset in the middle of CLEAR.
        for (int i = 0; i < 16; i++) begin
            rd_index        = {5'(2 * i + 1), 5'(2 * i)};
            rd_data         = {32'h0000_1234, 32'h0000_1234};
            rd_write_enable = 2'b11;
            tick();
        end
        idle_inputs();
        rs_index = {5'd0, 5'd31};
        #1;
        check("fill_r31", rs_data[0], 32'h0000_1234);
        check("fill_r0_nz", rs_data_nz[1], 32'h0000_1234);

        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        check("rst2_ready", o_ready, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        check("mid_clear_ready", o_ready, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        wait_ready(n_low);
        check("restart_clear_len", 32'(n_low), 32'd32);
        check_all_zero("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
